// File: rtl/reg_port_sequencer.sv
// Serialises one request (two optional operand reads, then an optional write-back) onto a
// single-port register stack. Optional REG_ZERO_EN hard-wires register 0 to zero.
module reg_port_sequencer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NIB_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rd_a,
  input  logic [NIB_WIDTH-1:0]  req_src_a,
  input  logic                  req_rd_b,
  input  logic [NIB_WIDTH-1:0]  req_src_b,
  input  logic                  req_wr,
  input  logic [NIB_WIDTH-1:0]  req_dst,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_a,
  output logic [WORD_WIDTH-1:0] rsp_b,
  output logic [NIB_WIDTH-1:0]  rs_regnum,
  output logic [WORD_WIDTH-1:0] rs_val,
  output logic                  rs_set,
  input  logic [WORD_WIDTH-1:0] rs_out
);

  typedef enum logic [2:0] {
    StIdle, StRdA, StRdB, StWrSetup, StWrPulse, StWrHold, StRsp
  } state_e;

  state_e                state;
  logic                  rd_b_q;
  logic                  wr_q;
  logic [NIB_WIDTH-1:0]  src_a_q;
  logic [NIB_WIDTH-1:0]  src_b_q;
  logic [NIB_WIDTH-1:0]  dst_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic                  rd_zero;
  logic                  wr_en;

  // rd_zero masks the read currently on the port; wr_en suppresses the set pulse
`ifdef REG_ZERO_EN
  assign rd_zero = (rs_regnum == '0);
  assign wr_en   = (dst_q != '0);
`else
  assign rd_zero = 1'b0;
  assign wr_en   = 1'b1;
`endif

  assign req_ready = (state == StIdle) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      rd_b_q    <= 1'b0;
      wr_q      <= 1'b0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      wdata_q   <= '0;
      rs_regnum <= '0;
      rs_val    <= '0;
      rs_set    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid && req_ready) begin
            rd_b_q  <= req_rd_b;
            wr_q    <= req_wr;
            src_a_q <= req_src_a;
            src_b_q <= req_src_b;
            dst_q   <= req_dst;
            wdata_q <= req_wdata;
            rsp_a   <= '0;
            rsp_b   <= '0;
            if (req_rd_a) begin
              state     <= StRdA;
              rs_regnum <= req_src_a;
            end else if (req_rd_b) begin
              state     <= StRdB;
              rs_regnum <= req_src_b;
            end else if (req_wr) begin
              state     <= StWrSetup;
              rs_regnum <= req_dst;
              rs_val    <= req_wdata;
            end else begin
              state     <= StRsp;
              rsp_valid <= 1'b1;
            end
          end
        end
        StRdA: begin
          rsp_a <= rd_zero ? '0 : rs_out;
          if (rd_b_q) begin
            state     <= StRdB;
            rs_regnum <= src_b_q;
          end else if (wr_q) begin
            state     <= StWrSetup;
            rs_regnum <= dst_q;
            rs_val    <= wdata_q;
          end else begin
            state     <= StRsp;
            rsp_valid <= 1'b1;
          end
        end
        StRdB: begin
          rsp_b <= rd_zero ? '0 : rs_out;
          if (wr_q) begin
            state     <= StWrSetup;
            rs_regnum <= dst_q;
            rs_val    <= wdata_q;
          end else begin
            state     <= StRsp;
            rsp_valid <= 1'b1;
          end
        end
        StWrSetup: begin
          state  <= StWrPulse;
          rs_set <= wr_en;
        end
        StWrPulse: begin
          state  <= StWrHold;
          rs_set <= 1'b0;
        end
        StWrHold: begin
          state     <= StRsp;
          rsp_valid <= 1'b1;
        end
        StRsp: begin
          if (rsp_ready) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Bench for reg_port_sequencer: behavioural register stack plus a response scoreboard.
// Honours REG_ZERO_EN the same way the design does.
module tb_reg_port_sequencer;

`ifdef REG_ZERO_EN
  localparam bit ZeroEn = 1'b1;
`else
  localparam bit ZeroEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rd_a, req_rd_b, req_wr;
  logic [3:0]  req_src_a, req_src_b, req_dst;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_a, rsp_b;
  logic [3:0]  rs_regnum;
  logic [15:0] rs_val, rs_out;
  logic        rs_set;

  logic [15:0] stack [16] = '{default: 16'h0};
  logic [15:0] shadow [16];
  logic [31:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          rises = 0;

  always #5 clk = ~clk;

  // Register stack: combinational read, write on rising set
  assign rs_out = stack[rs_regnum];
  always @(posedge rs_set) stack[rs_regnum] <= rs_val;
  always @(posedge rs_set) rises++;

  reg_port_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_a(req_rd_a), .req_src_a(req_src_a), .req_rd_b(req_rd_b), .req_src_b(req_src_b),
    .req_wr(req_wr), .req_dst(req_dst), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b), .rs_regnum(rs_regnum),
    .rs_val(rs_val), .rs_set(rs_set), .rs_out(rs_out)
  );

  function automatic logic [15:0] model_rd(input logic [3:0] r);
    return (ZeroEn && r == 4'd0) ? 16'h0 : shadow[r];
  endfunction

  // Predicts the response (reads before write), then drives through the accept edge
  task automatic issue(input logic ra, input logic [3:0] sa, input logic rb,
                       input logic [3:0] sb, input logic w, input logic [3:0] d,
                       input logic [15:0] wd);
    logic [15:0] ea, eb;
    ea = ra ? model_rd(sa) : 16'h0;
    eb = rb ? model_rd(sb) : 16'h0;
    exp_q.push_back({ea, eb});
    if (w && !(ZeroEn && d == 4'd0)) shadow[d] = wd;
    req_rd_a = ra; req_src_a = sa; req_rd_b = rb; req_src_b = sb;
    req_wr = w; req_dst = d; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Edges from accept (counted as 1) until rsp_valid; -1 on timeout
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic take_rsp(output logic [31:0] got, output logic [31:0] exp,
                          output logic rdy_after, output logic vld_after);
    got = {rsp_a, rsp_b};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rdy_after = req_ready;
    vld_after = rsp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", req_ready); end
    tests++; if ({rsp_valid, rs_set, rsp_a, rsp_b, rs_regnum, rs_val} !== '0) begin fails++; $display("FAIL rst_outputs got %b/%b/%h/%h/%h/%h want all 0", rsp_valid, rs_set, rsp_a, rsp_b, rs_regnum, rs_val); end
    reset = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 16'h5555);
    @(posedge clk); #1;
    tests++; if (rs_set !== 1'b1) begin fails++; $display("FAIL rst_pulse_setup got %b want 1", rs_set); end
    reset = 1'b1;
    #1;
    tests++; if (rs_set !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_pulse set=%b ready=%b want 0/0", rs_set, req_ready); end
    exp_q.delete();
    #1 reset = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_after ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_write_only();
    logic        s_set [1:4];
    logic [3:0]  s_num [1:4];
    logic [15:0] s_val [1:4];
    logic        s_vld [1:4];
    logic [31:0] got, exp;
    logic        rdy, vld;
    int          r0;
    r0 = rises;
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 16'h1234);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      s_set[k] = rs_set; s_num[k] = rs_regnum; s_val[k] = rs_val; s_vld[k] = rsp_valid;
    end
    tests++; if ({s_set[1], s_set[2], s_set[3]} !== 3'b010) begin fails++; $display("FAIL wr_set_shape got %b%b%b want 010", s_set[1], s_set[2], s_set[3]); end
    for (int k = 1; k <= 3; k++) begin
      tests++; if (s_num[k] !== 4'd3 || s_val[k] !== 16'h1234) begin fails++; $display("FAIL wr_port_stable edge %0d got %h/%h want 3/1234", k, s_num[k], s_val[k]); end
    end
    tests++; if ({s_vld[3], s_vld[4]} !== 2'b01) begin fails++; $display("FAIL wr_latency valid@3,4 got %b%b want 01", s_vld[3], s_vld[4]); end
    take_rsp(got, exp, rdy, vld);
    tests++; if (got !== exp || rises - r0 != 1) begin fails++; $display("FAIL wr_rsp got %h rises %0d want %h rises 1", got, rises - r0, exp); end
  endtask

  task automatic test_read_write();
    logic [31:0] got, exp;
    logic        rdy, vld;
    int          lat;
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 16'h0042);
    wait_rsp(lat);
    take_rsp(got, exp, rdy, vld);
    issue(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd3, 16'hBEEF);
    wait_rsp(lat);
    tests++; if (lat !== 6) begin fails++; $display("FAIL full_latency got %0d want 6", lat); end
    take_rsp(got, exp, rdy, vld);
    tests++; if (got !== exp || got !== 32'h1234_0042) begin fails++; $display("FAIL full_rsp got %h want %h", got, exp); end
    issue(1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0);
    wait_rsp(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL reads_latency got %0d want 3", lat); end
    take_rsp(got, exp, rdy, vld);
    tests++; if (got !== exp) begin fails++; $display("FAIL raw_rsp got %h want %h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got, exp;
    logic [15:0] a0, b0;
    logic        rdy, vld;
    int          lat;
    issue(1'b1, 4'd5, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0);
    wait_rsp(lat);
    a0 = rsp_a; b0 = rsp_b;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b1 || rsp_a !== a0 || rsp_b !== b0 || req_ready !== 1'b0) begin fails++; $display("FAIL bp_hold cyc %0d v=%b a=%h b=%h rdy=%b want 1/%h/%h/0", k, rsp_valid, rsp_a, rsp_b, req_ready, a0, b0); end
    end
    take_rsp(got, exp, rdy, vld);
    tests++; if (got !== exp) begin fails++; $display("FAIL bp_rsp got %h want %h", got, exp); end
    tests++; if (rdy !== 1'b1 || vld !== 1'b0) begin fails++; $display("FAIL bp_release ready=%b valid=%b want 1/0", rdy, vld); end
  endtask

  task automatic test_empty();
    logic [31:0] got, exp;
    logic        rdy, vld;
    int          lat, r0;
    r0 = rises;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    wait_rsp(lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL empty_latency got %0d want 1", lat); end
    take_rsp(got, exp, rdy, vld);
    tests++; if (got !== exp || rises != r0 || rdy !== 1'b1) begin fails++; $display("FAIL empty_rsp got %h rises %0d rdy %b want %h 0 1", got, rises - r0, rdy, exp); end
  endtask

  task automatic test_reg_zero();
    logic [31:0] got, exp;
    logic        rdy, vld;
    int          lat, r0;
    r0 = rises;
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 16'hFFFF);
    wait_rsp(lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL zero_wr_latency got %0d want 4", lat); end
    tests++; if (rises - r0 != (ZeroEn ? 0 : 1)) begin fails++; $display("FAIL zero_wr_set rises %0d want %0d", rises - r0, ZeroEn ? 0 : 1); end
    take_rsp(got, exp, rdy, vld);
    issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    wait_rsp(lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL zero_rd_latency got %0d want 2", lat); end
    take_rsp(got, exp, rdy, vld);
    tests++; if (got !== exp || got[31:16] !== (ZeroEn ? 16'h0 : 16'hFFFF)) begin fails++; $display("FAIL zero_rd_rsp got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    logic        rdy, vld;
    int          lat;
    issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd9, 16'hA5A5);
    wait_rsp(lat);
    take_rsp(got, exp, rdy, vld);
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", rdy); end
    issue(1'b1, 4'd9, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
    wait_rsp(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL b2b_latency got %0d want 3", lat); end
    take_rsp(got, exp, rdy, vld);
    tests++; if (got !== exp) begin fails++; $display("FAIL b2b_rsp got %h want %h", got, exp); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 16'h0;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_rd_a = 1'b0; req_rd_b = 1'b0; req_wr = 1'b0;
    req_src_a = '0; req_src_b = '0; req_dst = '0; req_wdata = '0;
    test_reset();
    test_write_only();
    test_read_write();
    test_backpressure();
    test_empty();
    test_reg_zero();
    test_back_to_back();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain left %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
